adpll_lock_sequencer: RTL and testbench
=======================================

// Module: adpll_lock_sequencer
// PURPOSE
//  Start-up and gain-scheduling controller for one network ADPLL node. Enables the DCO, holds the
//  error combiner's neighbour weights at zero during warm-up, then drives wide acquisition gains.
//  Once the combined phase error stays small, it switches to narrow tracking gains and flags lock.
//  On loss of lock it drops back to acquisition. Sits beside the node and drives its kp/ki/weight/enable inputs.
// PARAMETERS
//  PDET_WIDTH     8        width of signed combined phase error
//  KP_WIDTH       3        proportional gain code width
//  KI_WIDTH       4        integral gain code width
//  WEIGHT_WIDTH   4        per-neighbour weight width
//  KP_ACQ/KI_ACQ  3'b100/4'b0100  acquisition gains
//  KP_TRK/KI_TRK  3'b010/4'b0001  tracking gains
//  WEIGHT_ON      4'd2     weight applied to connected neighbours
//  WARMUP_CYCLES  1024     fpga_clk_i cycles in WARMUP
//  LOCK_THRESH    4        |error| <= this counts as in-lock sample
//  UNLOCK_THRESH  16       |error| > this counts as out-of-lock sample
//  LOCK_COUNT     64       consecutive in-lock samples to enter TRACK
//  UNLOCK_COUNT   8        consecutive out-of-lock samples to leave TRACK
//  ACQ_TIMEOUT    4096     samples allowed in ACQUIRE before FAIL
// PORTS
//  fpga_clk_i      in   1   single system clock; all logic on its rising edge
//  reset_i         in   1   asynchronous, active-low reset
//  start_i         in   1   level; request run from IDLE or FAIL
//  stop_i          in   1   level; return to IDLE from any state (priority over start_i)
//  gen_div8_i      in   1   node's divided DCO output, asynchronous to fpga_clk_i
//  error_i         in   PDET_WIDTH  signed combined error, sampled on each gen_div8_i rising edge
//  neighbour_en_i  in   4   connected mask {below,right,above,left}
//  enable_o        out  1   DCO enable
//  kp_o            out  KP_WIDTH    loop-filter proportional gain
//  ki_o            out  KI_WIDTH    loop-filter integral gain
//  weight_o        out  4*WEIGHT_WIDTH  {below,right,above,left} weights
//  locked_o        out  1   high only in TRACK
//  fail_o          out  1   high only in FAIL
//  lost_lock_o     out  1   one-cycle pulse on TRACK->ACQUIRE
//  state_o         out  3   encoded state (IDLE=0,WARMUP=1,ACQUIRE=2,TRACK=3,FAIL=4)
// BEHAVIOUR
//  Reset: state IDLE; enable_o=0, kp_o=KP_ACQ, ki_o=KI_ACQ, weight_o=0, locked_o=fail_o=lost_lock_o=0.
//  All counters are cleared and the synchroniser flops are zeroed.
//  Sample strobe: gen_div8_i passes a 2-flop synchroniser plus an edge flop; strobe is one cycle after
//  the synchronised rising edge, giving 3-4 cycles latency. error_i is registered on the strobe.
//  |error|: abs of signed value; most-negative code saturates to 2^(PDET_WIDTH-1)-1.
//  IDLE: outputs at reset values; start_i=1 & stop_i=0 -> WARMUP, cycle counter cleared.
//  WARMUP: enable_o=1, weight_o=0, acquisition gains. Counts fpga_clk_i cycles; at WARMUP_CYCLES-1 -> ACQUIRE.
//  ACQUIRE: acquisition gains. weight_o lane i = neighbour_en_i[i] ? WEIGHT_ON : 0.
//   Per strobe: if |err|<=LOCK_THRESH, run_cnt++, else run_cnt=0. timeout_cnt++ on every strobe.
//   run_cnt reaching LOCK_COUNT -> TRACK. Otherwise timeout_cnt reaching ACQ_TIMEOUT -> FAIL.
//   If both occur on the same strobe, TRACK wins.
//  TRACK: tracking gains, locked_o=1. Per strobe: if |err|>UNLOCK_THRESH, bad_cnt++, else bad_cnt=0.
//   bad_cnt reaching UNLOCK_COUNT -> ACQUIRE with lost_lock_o pulse, run_cnt and timeout_cnt cleared.
//   Errors between the two thresholds reset bad_cnt (hysteresis band).
//  FAIL: enable_o=1, acquisition gains, weights 0, fail_o=1. start_i re-edge (0->1) -> WARMUP.
//  stop_i=1 in any state -> IDLE next cycle; counters cleared.
//  Entry to WARMUP/ACQUIRE clears the counters of the target state.
//  neighbour_en_i change applies to weight_o next cycle.
//  All outputs registered; a state change is visible on outputs the cycle after the deciding strobe.
//  Counters saturate, never wrap. Strobes arriving in IDLE/WARMUP/FAIL are ignored.
// CONFIGURATION
//  ADPLL_SEQ_LOSS_CNT_EN defined: adds output loss_count_o [7:0], a saturating count of
//   TRACK->ACQUIRE events. It clears only on reset_i and holds at 255.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package adpll_seq_pkg holds the state encoding constants (3-bit) and the abs/saturate function.
//  One sub-module: adpll_edge_sync (2-flop sync + rising-edge strobe) for gen_div8_i.
//  FSM, counters and output registers live in the top module.
// TESTING
//  1 Reset then start_i=1: enable_o rises next cycle. weight_o=0 for 1024 cycles, then ACQUIRE with
//    neighbour_en_i=4'b0101 -> weight_o=16'h0202.
//  2 ACQUIRE, 64 strobes with error=+3: locked_o=1, kp_o=3'b010, ki_o=4'b0001.
//    Same test with one error=+5 at sample 40: lock only after 64 further good samples.
//  3 TRACK, 7 strobes error=-20 then one error=10: stays TRACK. Then 8x error=-20:
//    lost_lock_o pulses once, state_o=2.
//  4 ACQUIRE with error=40 for 4096 strobes: fail_o=1. start_i 0->1 -> WARMUP.
//  5 error=8'h80 in TRACK treated as 127 (out-of-lock). stop_i mid-WARMUP: IDLE next cycle, all outputs at reset values.
//  6 Assert reset_i low mid-TRACK: all outputs reset asynchronously.
//    With ADPLL_SEQ_LOSS_CNT_EN, 3 forced losses give loss_count_o=3.

Source files
------------

// File: rtl/adpll_seq_pkg.sv
// Shared definitions for the ADPLL lock sequencer: state encoding and the
// arithmetic helpers used on the combined phase error and the run counters.
package adpll_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARMUP  = 3'd1,
    S_ACQUIRE = 3'd2,
    S_TRACK   = 3'd3,
    S_FAIL    = 3'd4
  } state_e;

  // All sequencer counters share one width; wide enough for the acquisition timeout.
  localparam int CNT_W = 16;

  // Magnitude of a sign-extended w-bit error. The most-negative code has no positive
  // counterpart, so it is clamped to the largest positive value.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] v, input int unsigned w);
    logic [31:0] lim;
    logic [31:0] m;
    lim = (32'd1 << (w - 1)) - 32'd1;
    m   = (v < 0) ? 32'(-v) : 32'(v);
    if (m > lim) m = lim;
    return m;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/adpll_edge_sync.sv
// Brings the asynchronous divided DCO clock into the system domain and emits a
// one-cycle strobe registered one cycle after the synchronised rising edge.
module adpll_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic strobe_o
);

  logic meta_q, sync_q, prev_q, strobe_q;

  // Two-flop synchroniser, edge history flop and registered rising-edge strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      prev_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      meta_q   <= async_i;
      sync_q   <= meta_q;
      prev_q   <= sync_q;
      strobe_q <= sync_q & ~prev_q;
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/adpll_lock_sequencer.sv
// Start-up and gain-scheduling controller for one ADPLL node: warm-up, wide
// acquisition gains, narrow tracking gains once the error settles, and fallback
// on loss of lock. Define ADPLL_SEQ_LOSS_CNT_EN to add loss_count_o, a saturating
// count of TRACK->ACQUIRE events.
module adpll_lock_sequencer
  import adpll_seq_pkg::*;
#(
  parameter int                      PDET_WIDTH    = 8,
  parameter int                      KP_WIDTH      = 3,
  parameter int                      KI_WIDTH      = 4,
  parameter int                      WEIGHT_WIDTH  = 4,
  parameter logic [KP_WIDTH-1:0]     KP_ACQ        = 3'b100,
  parameter logic [KI_WIDTH-1:0]     KI_ACQ        = 4'b0100,
  parameter logic [KP_WIDTH-1:0]     KP_TRK        = 3'b010,
  parameter logic [KI_WIDTH-1:0]     KI_TRK        = 4'b0001,
  parameter logic [WEIGHT_WIDTH-1:0] WEIGHT_ON     = 4'd2,
  parameter int                      WARMUP_CYCLES = 1024,
  parameter int                      LOCK_THRESH   = 4,
  parameter int                      UNLOCK_THRESH = 16,
  parameter int                      LOCK_COUNT    = 64,
  parameter int                      UNLOCK_COUNT  = 8,
  parameter int                      ACQ_TIMEOUT   = 4096
) (
  input  logic                      fpga_clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      gen_div8_i,
  input  logic [PDET_WIDTH-1:0]     error_i,
  input  logic [3:0]                neighbour_en_i,
  output logic                      enable_o,
  output logic [KP_WIDTH-1:0]       kp_o,
  output logic [KI_WIDTH-1:0]       ki_o,
  output logic [4*WEIGHT_WIDTH-1:0] weight_o,
  output logic                      locked_o,
  output logic                      fail_o,
  output logic                      lost_lock_o,
  output logic [2:0]                state_o
`ifdef ADPLL_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0]                loss_count_o
`else
`endif
);

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_C    = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] UNLOCK_C  = CNT_W'(UNLOCK_COUNT);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(ACQ_TIMEOUT);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cyc_q, cyc_d, run_q, run_d, to_q, to_d, bad_q, bad_d;
  logic [CNT_W-1:0]        run_n, to_n, bad_n;
  logic                    strobe, smp_q, start_q, lost_d;
  logic signed [PDET_WIDTH-1:0] err_q;
  logic [31:0]             mag;

  logic                      enable_q, enable_d, locked_q, locked_d, fail_q, fail_d, lost_q;
  logic [KP_WIDTH-1:0]       kp_q, kp_d;
  logic [KI_WIDTH-1:0]       ki_q, ki_d;
  logic [4*WEIGHT_WIDTH-1:0] weight_q, weight_d;

  adpll_edge_sync u_sync (
    .clk_i    (fpga_clk_i),
    .rst_ni   (reset_i),
    .async_i  (gen_div8_i),
    .strobe_o (strobe)
  );

  // Capture the error on each strobe; smp_q marks the cycle the captured sample is evaluated.
  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      err_q   <= '0;
      smp_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      smp_q   <= strobe;
      start_q <= start_i;
      if (strobe) err_q <= error_i;
    end
  end

  assign mag   = abs_sat(32'(err_q), PDET_WIDTH);
  assign run_n = (mag <= 32'(LOCK_THRESH)) ? sat_inc(run_q) : '0;
  assign to_n  = sat_inc(to_q);
  assign bad_n = (mag > 32'(UNLOCK_THRESH)) ? sat_inc(bad_q) : '0;

  // State and counter register.
  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      run_q   <= '0;
      to_q    <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      run_q   <= run_d;
      to_q    <= to_d;
      bad_q   <= bad_d;
    end
  end

  // Next-state and counter logic; stop_i overrides everything.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    run_d   = run_q;
    to_d    = to_q;
    bad_d   = bad_q;
    lost_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_WARMUP;
          cyc_d   = '0;
        end
      end
      S_WARMUP: begin
        if (cyc_q >= WARM_LAST) begin
          state_d = S_ACQUIRE;
          run_d   = '0;
          to_d    = '0;
        end else begin
          cyc_d = sat_inc(cyc_q);
        end
      end
      S_ACQUIRE: begin
        if (smp_q) begin
          run_d = run_n;
          to_d  = to_n;
          // Reaching lock on the same sample as the timeout still counts as lock.
          if (run_n >= LOCK_C) begin
            state_d = S_TRACK;
            bad_d   = '0;
          end else if (to_n >= TIMEOUT_C) begin
            state_d = S_FAIL;
          end
        end
      end
      S_TRACK: begin
        if (smp_q) begin
          bad_d = bad_n;
          if (bad_n >= UNLOCK_C) begin
            state_d = S_ACQUIRE;
            run_d   = '0;
            to_d    = '0;
            lost_d  = 1'b1;
          end
        end
      end
      S_FAIL: begin
        // Only a fresh start request restarts; a held level does not.
        if (start_i && !start_q) begin
          state_d = S_WARMUP;
          cyc_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (stop_i) begin
      state_d = S_IDLE;
      cyc_d   = '0;
      run_d   = '0;
      to_d    = '0;
      bad_d   = '0;
      lost_d  = 1'b0;
    end
  end

  // Output values decoded from the next state so they register alongside it.
  always_comb begin
    enable_d = (state_d != S_IDLE);
    kp_d     = (state_d == S_TRACK) ? KP_TRK : KP_ACQ;
    ki_d     = (state_d == S_TRACK) ? KI_TRK : KI_ACQ;
    locked_d = (state_d == S_TRACK);
    fail_d   = (state_d == S_FAIL);
    weight_d = '0;
    for (int i = 0; i < 4; i++) begin
      if ((state_d == S_ACQUIRE || state_d == S_TRACK) && neighbour_en_i[i])
        weight_d[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = WEIGHT_ON;
    end
  end

  // Output registers.
  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      enable_q <= 1'b0;
      kp_q     <= KP_ACQ;
      ki_q     <= KI_ACQ;
      weight_q <= '0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      enable_q <= enable_d;
      kp_q     <= kp_d;
      ki_q     <= ki_d;
      weight_q <= weight_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
      lost_q   <= lost_d;
    end
  end

  assign enable_o    = enable_q;
  assign kp_o        = kp_q;
  assign ki_o        = ki_q;
  assign weight_o    = weight_q;
  assign locked_o    = locked_q;
  assign fail_o      = fail_q;
  assign lost_lock_o = lost_q;
  assign state_o     = state_q;

`ifdef ADPLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q;

  // Lifetime count of lock losses; only reset clears it.
  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i)                   loss_q <= '0;
    else if (lost_d && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
  end

  assign loss_count_o = loss_q;
`else
  // Loss counter not built.
`endif

endmodule

// File: tb/tb_adpll_lock_sequencer.sv
// Directed bench for adpll_lock_sequencer: a table of error strobes drives the
// acquire/track/loss behaviour, hand sequences cover warm-up, timeout, stop and reset.
module tb_adpll_lock_sequencer;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        gen_div8_i = 1'b0;
  logic [7:0]  error_i = 8'd0;
  logic [3:0]  neighbour_en_i = 4'b0101;
  logic        enable_o, locked_o, fail_o, lost_lock_o;
  logic [2:0]  kp_o, state_o;
  logic [3:0]  ki_o;
  logic [15:0] weight_o;
`ifdef ADPLL_SEQ_LOSS_CNT_EN
  logic [7:0]  loss_count_o;
`endif

  adpll_lock_sequencer dut (
    .fpga_clk_i     (clk),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .gen_div8_i     (gen_div8_i),
    .error_i        (error_i),
    .neighbour_en_i (neighbour_en_i),
    .enable_o       (enable_o),
    .kp_o           (kp_o),
    .ki_o           (ki_o),
    .weight_o       (weight_o),
    .locked_o       (locked_o),
    .fail_o         (fail_o),
    .lost_lock_o    (lost_lock_o),
    .state_o        (state_o)
`ifdef ADPLL_SEQ_LOSS_CNT_EN
    ,
    .loss_count_o   (loss_count_o)
`endif
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  int losses_seen = 0;

  // Count lost-lock pulses away from the active edge; a pulse longer than one cycle over-counts.
  always @(negedge clk) if (lost_lock_o === 1'b1) losses_seen++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One gen_div8 period with a fixed error; its effect is on the outputs when this returns.
  task automatic strobe(input logic [7:0] e);
    error_i = e;
    gen_div8_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 gen_div8_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Expected outputs as a function of the expected state.
  task automatic chk_outs(input string tag, input logic [2:0] st, input logic [15:0] w);
    chk({tag, ".state"},  32'(state_o),  32'(st));
    chk({tag, ".enable"}, 32'(enable_o), 32'(st != 3'd0));
    chk({tag, ".kp"},     32'(kp_o),     (st == 3'd3) ? 32'h2 : 32'h4);
    chk({tag, ".ki"},     32'(ki_o),     (st == 3'd3) ? 32'h1 : 32'h4);
    chk({tag, ".weight"}, 32'(weight_o), 32'(w));
    chk({tag, ".locked"}, 32'(locked_o), 32'(st == 3'd3));
    chk({tag, ".fail"},   32'(fail_o),   32'(st == 3'd4));
  endtask

  typedef struct {
    logic [7:0] err;
    int         n;
    logic [2:0] st;
    int         losses;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int n;
    logic wbad;

    tbl[0]  = '{8'd3,   39, 3'd2, 0};  // good samples 1..39
    tbl[1]  = '{8'd5,    1, 3'd2, 0};  // sample 40 just outside lock threshold
    tbl[2]  = '{8'd3,   63, 3'd2, 0};  // one short of a fresh 64-run
    tbl[3]  = '{8'd3,    1, 3'd3, 0};  // 64th consecutive good -> TRACK
    tbl[4]  = '{8'hEC,   7, 3'd3, 0};  // -20 x7
    tbl[5]  = '{8'd10,   1, 3'd3, 0};  // hysteresis band clears bad run
    tbl[6]  = '{8'hEC,   7, 3'd3, 0};
    tbl[7]  = '{8'd16,   1, 3'd3, 0};  // exactly UNLOCK_THRESH is not bad
    tbl[8]  = '{8'hEC,   7, 3'd3, 0};
    tbl[9]  = '{8'hEC,   1, 3'd2, 1};  // 8th bad -> ACQUIRE, one pulse
    tbl[10] = '{8'hFC,  63, 3'd2, 1};  // -4 is in-lock
    tbl[11] = '{8'hFC,   1, 3'd3, 1};
    tbl[12] = '{8'h80,   7, 3'd3, 1};  // most-negative code saturates to 127
    tbl[13] = '{8'h80,   1, 3'd2, 2};
    tbl[14] = '{8'd3,   64, 3'd3, 2};
    tbl[15] = '{8'd40,   8, 3'd2, 3};

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 3'd0, 16'h0000);
    chk("reset.lost", 32'(lost_lock_o), 32'd0);
    reset_i = 1'b1;
    tick();

    // Start: enable next cycle, weights held at zero through 1024 warm-up cycles.
    start_i = 1'b1;
    tick();
    chk_outs("start", 3'd1, 16'h0000);
    n = 0;
    wbad = 1'b0;
    while (state_o == 3'd1 && n < 1100) begin
      if (weight_o != 16'h0000) wbad = 1'b1;
      tick();
      n++;
    end
    chk("warmup.cycles", 32'(n), 32'd1024);
    chk("warmup.weight_zero", 32'(wbad), 32'd0);
    chk_outs("acq_entry", 3'd2, 16'h0202);

    // Table of strobe runs through acquire, track and losses.
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < tbl[r].n; k++) strobe(tbl[r].err);
      chk_outs($sformatf("row%0d", r), tbl[r].st, 16'h0202);
      chk($sformatf("row%0d.losses", r), 32'(losses_seen), 32'(tbl[r].losses));
    end
`ifdef ADPLL_SEQ_LOSS_CNT_EN
    chk("loss_count3", 32'(loss_count_o), 32'd3);
`endif

    // Acquisition timeout: 4095 bad samples stay in ACQUIRE, the 4096th fails.
    for (int k = 0; k < 4095; k++) strobe(8'd40);
    chk("timeout.pre", 32'(state_o), 32'd2);
    strobe(8'd40);
    chk_outs("timeout", 3'd4, 16'h0000);
    repeat (20) tick();
    chk("fail.level_start_ignored", 32'(state_o), 32'd4);
    start_i = 1'b0;
    tick();
    start_i = 1'b1;
    tick();
    chk_outs("fail.restart", 3'd1, 16'h0000);

    // Stop mid-warm-up returns everything to reset values next cycle.
    repeat (100) tick();
    stop_i = 1'b1;
    start_i = 1'b0;
    tick();
    chk_outs("stop", 3'd0, 16'h0000);
    chk("stop.lost", 32'(lost_lock_o), 32'd0);
    stop_i = 1'b0;
    tick();
    chk("stop.idle_hold", 32'(state_o), 32'd0);

    // Back to TRACK, neighbour mask change, then asynchronous reset.
    start_i = 1'b1;
    tick();
    n = 0;
    while (state_o != 3'd2 && n < 1100) begin
      tick();
      n++;
    end
    chk("rerun.acq", 32'(state_o), 32'd2);
    for (int k = 0; k < 64; k++) strobe(8'd0);
    chk_outs("rerun.track", 3'd3, 16'h0202);
    neighbour_en_i = 4'b1010;
    tick();
    chk("nbr_change", 32'(weight_o), 32'h2020);
    #2 reset_i = 1'b0;
    #1;
    chk_outs("async_reset", 3'd0, 16'h0000);
    chk("async_reset.lost", 32'(lost_lock_o), 32'd0);
`ifdef ADPLL_SEQ_LOSS_CNT_EN
    chk("async_reset.loss_count", 32'(loss_count_o), 32'd0);
`endif
    tick();
    reset_i = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
